// File: rtl/imem_fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package imem_fetch_pkg;

   localparam int unsigned INS_ADDRESS = 9;
   localparam int unsigned INS_W       = 32;
   localparam int unsigned PC_STEP     = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_HALT  = 2'd2,
      ST_FAULT = 2'd3
   } fetch_state_e;

   typedef struct packed {
      logic [INS_ADDRESS-1:0] pc;
      logic [INS_W-1:0]       instr;
   } fetch_entry_t;

endpackage

// File: rtl/imem_fetch_fifo.sv
// Shift-organised fetch buffer: entry 0 is always the head, so the head is a flop.
module fetch_fifo
   import imem_fetch_pkg::*;
#(
   parameter int unsigned DEPTH = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push,
   input  logic         pop,
   input  logic         flush,
   input  fetch_entry_t wdata,
   output fetch_entry_t head,
   output logic         full,
   output logic         empty
);

   localparam int unsigned CNT_W = $clog2(DEPTH + 1);
   localparam int unsigned IDX_W = $clog2(DEPTH);

   fetch_entry_t     mem [DEPTH];
   logic [CNT_W-1:0] count;
   logic [CNT_W-1:0] count_nxt;
   logic [IDX_W-1:0] wr_idx;
   logic             do_pop;
   logic             do_push;

   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign head    = mem[0];

   // Write slot accounts for the shift-down caused by a simultaneous pop.
   always_comb begin
      wr_idx    = IDX_W'(do_pop ? count - CNT_W'(1) : count);
      count_nxt = count;
      if (flush) begin
         count_nxt = '0;
      end else begin
         count_nxt = count + CNT_W'(do_push) - CNT_W'(do_pop);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
         empty <= 1'b1;
         full  <= 1'b0;
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem[i] <= '0;
         end
      end else begin
         count <= count_nxt;
         empty <= (count_nxt == '0);
         full  <= (count_nxt == CNT_W'(DEPTH));
         if (!flush) begin
            if (do_pop) begin
               for (int i = 0; i < int'(DEPTH) - 1; i++) begin
                  mem[i] <= mem[i+1];
               end
            end
            if (do_push) begin
               mem[wr_idx] <= wdata;
            end
         end
      end
   end

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Instruction fetch sequencer: owns the PC, buffers words, handles redirect/halt/fault.
// Optional performance counters enabled by defining FETCH_PERF_CNT_EN.
module imem_fetch_ctrl
   import imem_fetch_pkg::*;
#(
   parameter logic [INS_ADDRESS-1:0] RESET_PC   = '0,
   parameter int unsigned            FIFO_DEPTH = 2
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic                   halt_req,
   input  logic                   redirect_valid,
   input  logic [INS_ADDRESS-1:0] redirect_pc,
   output logic [INS_ADDRESS-1:0] imem_ra,
   input  logic [INS_W-1:0]       imem_rd,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [INS_W-1:0]       out_instr,
   output logic [INS_ADDRESS-1:0] out_pc,
   output logic                   fault,
   output logic [1:0]             state_o
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0]            perf_fetched,
   output logic [31:0]            perf_stall
`endif
);

   fetch_state_e           state;
   fetch_state_e           state_nxt;
   logic [INS_ADDRESS-1:0] pc;
   logic [INS_ADDRESS-1:0] pc_nxt;
   logic                   fault_nxt;
   logic                   pop;
   logic                   fetch;
   logic                   misaligned;
   logic                   full;
   logic                   empty;
   fetch_entry_t           head;
   fetch_entry_t           wr_entry;

   assign misaligned = redirect_valid && (redirect_pc[1:0] != 2'b00);
   assign pop        = out_valid && out_ready;
   assign fetch      = (state == ST_RUN) && !redirect_valid && (!full || pop);
   assign wr_entry   = '{pc: pc, instr: imem_rd};

   assign imem_ra   = pc;
   assign out_valid = !empty;
   assign out_pc    = head.pc;
   assign out_instr = head.instr;
   assign state_o   = state;

   fetch_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (fetch),
      .pop   (pop),
      .flush (redirect_valid),
      .wdata (wr_entry),
      .head  (head),
      .full  (full),
      .empty (empty)
   );

   // Redirect overrides everything; a misaligned target parks in FAULT with pc untouched.
   always_comb begin
      state_nxt = state;
      pc_nxt    = pc;
      fault_nxt = fault;
      if (redirect_valid) begin
         if (misaligned) begin
            state_nxt = ST_FAULT;
            fault_nxt = 1'b1;
         end else begin
            pc_nxt = redirect_pc;
            if (state == ST_FAULT) begin
               state_nxt = ST_HALT;
               fault_nxt = 1'b0;
            end
         end
      end else begin
         if (fetch) begin
            pc_nxt = pc + INS_ADDRESS'(PC_STEP);
         end
         case (state)
            ST_IDLE, ST_HALT: if (start && !halt_req) state_nxt = ST_RUN;
            ST_RUN:           if (halt_req)           state_nxt = ST_HALT;
            default:          state_nxt = state;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
         pc    <= RESET_PC;
         fault <= 1'b0;
      end else begin
         state <= state_nxt;
         pc    <= pc_nxt;
         fault <= fault_nxt;
      end
   end

`ifdef FETCH_PERF_CNT_EN
   // Counters survive redirects; only reset clears them.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_fetched <= '0;
         perf_stall   <= '0;
      end else begin
         perf_fetched <= perf_fetched + 32'(fetch);
         if ((state == ST_RUN) && full && !pop) begin
            perf_stall <= perf_stall + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Self-checking bench for imem_fetch_ctrl: queue-based reference model plus directed checks.
module tb_imem_fetch_ctrl;

   localparam int AW    = 9;
   localparam int DEPTH = 2;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic          halt_req = 1'b0;
   logic          redirect_valid = 1'b0;
   logic [AW-1:0] redirect_pc = '0;
   logic [AW-1:0] imem_ra;
   logic [31:0]   imem_rd;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [31:0]   out_instr;
   logic [AW-1:0] out_pc;
   logic          fault;
   logic [1:0]    state_o;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0]   perf_fetched;
   logic [31:0]   perf_stall;
`endif

   always #5 clk = ~clk;

   logic [31:0] mem [128];
   assign imem_rd = mem[imem_ra[8:2]];

   imem_fetch_ctrl #(
      .RESET_PC   (9'h000),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .start          (start),
      .halt_req       (halt_req),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .imem_ra        (imem_ra),
      .imem_rd        (imem_rd),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_instr      (out_instr),
      .out_pc         (out_pc),
      .fault          (fault),
      .state_o        (state_o)
`ifdef FETCH_PERF_CNT_EN
      ,
      .perf_fetched   (perf_fetched),
      .perf_stall     (perf_stall)
`endif
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: buffered words as a queue, pc as a number, state as its spec code.
   typedef struct {
      logic [AW-1:0] pc;
      logic [31:0]   instr;
   } ent_t;

   ent_t          q[$];
   logic [AW-1:0] m_pc    = '0;
   logic [1:0]    m_state = 2'd0;
   logic          m_fault = 1'b0;

   task automatic model_step();
      bit   pop_m;
      bit   fetch_m;
      ent_t e;
      pop_m = (q.size() != 0) && out_ready;
      if (redirect_valid) begin
         q.delete();
         if (redirect_pc[1:0] != 2'b00) begin
            m_state = 2'd3;
            m_fault = 1'b1;
         end else begin
            m_pc = redirect_pc;
            if (m_state == 2'd3) begin
               m_state = 2'd2;
               m_fault = 1'b0;
            end
         end
         return;
      end
      fetch_m = (m_state == 2'd1) && ((q.size() < DEPTH) || pop_m);
      if (pop_m) void'(q.pop_front());
      if (fetch_m) begin
         e.pc    = m_pc;
         e.instr = mem[m_pc[8:2]];
         q.push_back(e);
         m_pc = m_pc + 9'd4;
      end
      if ((m_state == 2'd0 || m_state == 2'd2) && start && !halt_req) m_state = 2'd1;
      else if (m_state == 2'd1 && halt_req) m_state = 2'd2;
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q.delete();
         m_pc    = '0;
         m_state = 2'd0;
         m_fault = 1'b0;
      end else begin
         model_step();
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         check("cmp_out_valid", 32'(out_valid), 32'(q.size() != 0));
         if (q.size() != 0) begin
            check("cmp_out_pc", 32'(out_pc), 32'(q[0].pc));
            check("cmp_out_instr", out_instr, q[0].instr);
         end
         check("cmp_imem_ra", 32'(imem_ra), 32'(m_pc));
         check("cmp_state", 32'(state_o), 32'(m_state));
         check("cmp_fault", 32'(fault), 32'(m_fault));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic redirect(input logic [AW-1:0] target);
      redirect_valid = 1'b1;
      redirect_pc    = target;
      tick();
      redirect_valid = 1'b0;
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
      check({tag, "_state"},     32'(state_o),   32'd0);
      check({tag, "_imem_ra"},   32'(imem_ra),   32'h000);
      check({tag, "_fault"},     32'(fault),     32'd0);
      check({tag, "_out_pc"},    32'(out_pc),    32'd0);
      check({tag, "_out_instr"}, out_instr,      32'd0);
   endtask

   initial begin
      for (int i = 0; i < 128; i++) mem[i] = 32'hC0DE_0000 + 32'(i);
      mem[0] = 32'h0000_7033;
      mem[1] = 32'h0010_0093;

      #12;
      check_reset_values("rst");
      rst_n = 1'b1;

      // Sequential fetch and first-word latency
      out_ready = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      check("seq_state_run", 32'(state_o), 32'd1);
      check("seq_no_valid_yet", 32'(out_valid), 32'd0);
      tick();
      check("seq_first_valid", 32'(out_valid), 32'd1);
      check("seq_pc0", 32'(out_pc), 32'h000);
      check("seq_instr0", out_instr, 32'h0000_7033);
      tick();
      check("seq_pc1", 32'(out_pc), 32'h004);
      check("seq_instr1", out_instr, 32'h0010_0093);

      // Backpressure: refill from 0x000 with decode stalled
      out_ready = 1'b0;
      redirect(9'h000);
      tick();
      tick();
      repeat (5) begin
         tick();
         check("bp_ra_frozen", 32'(imem_ra), 32'h008);
         check("bp_head", 32'(out_pc), 32'h000);
      end
      out_ready = 1'b1;
      tick();
      check("bp_pc4", 32'(out_pc), 32'h004);
      tick();
      check("bp_pc8", 32'(out_pc), 32'h008);
      tick();
      check("bp_pcC", 32'(out_pc), 32'h00C);

      // Redirect while a pop is in progress
      redirect(9'h04C);
      check("rd_bubble", 32'(out_valid), 32'd0);
      tick();
      check("rd_pc4C", 32'(out_pc), 32'h04C);
      check("rd_instr4C", out_instr, 32'hC0DE_0013);
      tick();
      check("rd_pc50", 32'(out_pc), 32'h050);

      // Wrap-around of the byte address
      redirect(9'h1FC);
      tick();
      check("wrap_pc1FC", 32'(out_pc), 32'h1FC);
      check("wrap_instr1FC", out_instr, 32'hC0DE_007F);
      tick();
      check("wrap_pc000", 32'(out_pc), 32'h000);

      // Misaligned redirect, FAULT ignores start/halt, aligned redirect recovers
      redirect(9'h046);
      check("flt_fault", 32'(fault), 32'd1);
      check("flt_state", 32'(state_o), 32'd3);
      check("flt_no_valid", 32'(out_valid), 32'd0);
      start = 1'b1;
      tick();
      start = 1'b0;
      check("flt_start_ignored", 32'(state_o), 32'd3);
      halt_req = 1'b1;
      tick();
      halt_req = 1'b0;
      check("flt_halt_ignored", 32'(state_o), 32'd3);
      redirect(9'h060);
      check("flt_cleared", 32'(fault), 32'd0);
      check("flt_to_halt", 32'(state_o), 32'd2);
      check("flt_pc_loaded", 32'(imem_ra), 32'h060);
      tick();
      check("flt_halt_nofetch", 32'(out_valid), 32'd0);
      start = 1'b1;
      tick();
      start = 1'b0;
      check("flt_restart", 32'(state_o), 32'd1);
      tick();
      check("flt_first_pc", 32'(out_pc), 32'h060);

      // Halt and start together: halt wins, buffered words drain
      out_ready = 1'b0;
      tick();
      halt_req = 1'b1;
      start    = 1'b1;
      tick();
      halt_req = 1'b0;
      start    = 1'b0;
      check("halt_state", 32'(state_o), 32'd2);
      check("halt_ra", 32'(imem_ra), 32'h068);
      out_ready = 1'b1;
      tick();
      check("halt_drain", 32'(out_pc), 32'h064);
      tick();
      check("halt_empty", 32'(out_valid), 32'd0);
      check("halt_ra_hold", 32'(imem_ra), 32'h068);

      // Asynchronous reset in the middle of streaming
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      check("pre_rst_valid", 32'(out_valid), 32'd1);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_values("arst");
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      check("post_rst_state", 32'(state_o), 32'd0);
      check("post_rst_valid", 32'(out_valid), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
